// File: rtl/bt_cmd_arbiter.sv
// Round-robin arbiter sharing one snd_cmd engine among NUM_REQ requesters, with a response timeout and an inter-command gap.
// Optional macro BT_ARB_RETRY_EN: reissue a timed-out command up to MAX_RETRY times before reporting err.
module bt_cmd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int GAP_CYC     = 1024,
    parameter int MAX_RETRY   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [5*NUM_REQ-1:0]   req_start,
    input  logic [4*NUM_REQ-1:0]   req_len,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic                   send,
    output logic [4:0]             cmd_start,
    output logic [3:0]             cmd_len,
    input  logic                   resp_rcvd,
    output logic                   busy
);

    // state     | meaning
    // IDLE      | waiting for any request; grants and captures fields
    // ISSUE     | pulses send for the captured command
    // WAIT_RESP | waiting for resp_rcvd, timeout counter running
    // GAP       | enforced idle time before the next grant
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, GAP} state_t;

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NREQ     = (PTR_W + 1)'(NUM_REQ);

`ifdef BT_ARB_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [4:0]         cmd_start_q, cmd_start_d;
    logic [3:0]         cmd_len_q, cmd_len_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               send_q, send_d;
    logic               busy_q, busy_d;

    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W:0]     cand;
    logic [4:0]         sel_start;
    logic [3:0]         sel_len;
    logic [NUM_REQ-1:0] sel_vec;
    logic [NUM_REQ-1:0] owner_vec;
    logic               retry_ok;

    // First set request at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!sel_found && req[cand[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        sel_start = '0;
        sel_len   = '0;
        sel_vec   = '0;
        owner_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == PTR_W'(i)) begin
                sel_start  = req_start[5*i +: 5];
                sel_len    = req_len[4*i +: 4];
                sel_vec[i] = 1'b1;
            end
            owner_vec[i] = (owner_q == PTR_W'(i));
        end
    end

    assign retry_ok = RETRY_EN && (retry_q < RTY_MAX);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        retry_d     = retry_q;
        cmd_start_d = cmd_start_q;
        cmd_len_d   = cmd_len_q;
        gnt_d       = '0;
        done_d      = '0;
        err_d       = '0;
        send_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    gnt_d       = sel_vec;
                    cmd_start_d = sel_start;
                    cmd_len_d   = sel_len;
                    owner_d     = sel_idx;
                    ptr_d       = (sel_idx == LAST_REQ) ? '0 : sel_idx + PTR_W'(1);
                    retry_d     = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                send_d   = 1'b1;
                to_cnt_d = '0;
                state_d  = WAIT_RESP;
            end
            WAIT_RESP: begin
                // A response on the terminal-count cycle still counts as success.
                if (resp_rcvd) begin
                    done_d    = owner_vec;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else if (to_cnt_q == TO_LAST) begin
                    if (retry_ok) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = ISSUE;
                    end else begin
                        err_d     = owner_vec;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            retry_q     <= '0;
            cmd_start_q <= '0;
            cmd_len_q   <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            send_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            to_cnt_q    <= to_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            retry_q     <= retry_d;
            cmd_start_q <= cmd_start_d;
            cmd_len_q   <= cmd_len_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            send_q      <= send_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign send      = send_q;
    assign cmd_start = cmd_start_q;
    assign cmd_len   = cmd_len_q;
    assign busy      = busy_q;

endmodule
